prefix_addsub_pipe: RTL and testbench

PREFIX_ADDSUB_PIPE -- requirements
Module: prefix_addsub_pipe

---
 rtl/prefix_pkg.sv | 15 +
 rtl/prefix_carry_8.sv | 32 +++
 rtl/prefix_addsub_pipe.sv | 113 +++++++++++
 tb/tb_prefix_addsub_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_pkg.sv
// Shared definitions for the parallel-prefix add/subtract pipeline.
package prefix_pkg;

   localparam int WIDTH = 8;

   // Operand-derived state handed from stage 1 to stage 2.
   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic             c0;
      logic             sub;
      logic             a_msb;
   } s1_payload_t;

endpackage

// File: rtl/prefix_carry_8.sv
// Combinational 8-bit Kogge-Stone carry network: c[i+1] = G[i:0] | (P[i:0] & c0).
module prefix_carry_8 (
   input  logic [7:0] g,
   input  logic [7:0] p,
   input  logic       c0,
   output logic [8:0] c
);

   // Level k holds group (G,P) spanning up to 2^k bits ending at each position.
   logic [3:0][7:0] gl;
   logic [3:0][7:0] pl;

   assign gl[0] = g;
   assign pl[0] = p;

   for (genvar k = 0; k < 3; k++) begin : g_level
      localparam int D = 1 << k;
      for (genvar i = 0; i < 8; i++) begin : g_bit
         if (i >= D) begin : g_merge
            assign gl[k+1][i] = gl[k][i] | (pl[k][i] & gl[k][i-D]);
            assign pl[k+1][i] = pl[k][i] & pl[k][i-D];
         end else begin : g_pass
            assign gl[k+1][i] = gl[k][i];
            assign pl[k+1][i] = pl[k][i];
         end
      end
   end

   assign c[0]   = c0;
   assign c[8:1] = gl[3] | (pl[3] & {8{c0}});

endmodule

// File: rtl/prefix_addsub_pipe.sv
// Two-stage elastic add/subtract pipeline with parallel-prefix carries,
// optional signed saturation and carry/borrow, overflow and zero flags.
module prefix_addsub_pipe
   import prefix_pkg::*;
#(
   parameter bit SAT = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       sub,
   input  logic       cin,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] sum,
   output logic       cout,
   output logic       ovf,
   output logic       zero
);

   // Clamp toward the sign of operand A on signed overflow; wrap otherwise.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                 input logic             ovf_in,
                                                 input logic             a_msb);
      if (SAT && ovf_in)
         return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      return raw;
   endfunction

   logic             vld_p1;
   logic             vld_p2;
   logic             ld_p1;
   logic             ld_p2;
   s1_payload_t      pay_d;
   s1_payload_t      pay_p1;
   logic [WIDTH-1:0] beff;
   logic [WIDTH:0]   c_w;
   logic [WIDTH-1:0] sum_raw;
   logic [WIDTH-1:0] sum_fin;
   logic             ovf_w;
   logic             cout_w;
   logic [WIDTH-1:0] sum_p2;
   logic             cout_p2;
   logic             ovf_p2;
   logic             zero_p2;

   // Stage 2 frees up when empty or drained; stage 1 follows stage 2.
   assign ld_p2    = ~vld_p2 | out_ready;
   assign ld_p1    = ~vld_p1 | ld_p2;
   assign in_ready = ld_p1;

   // Subtraction is A + ~B + ~borrow, so B and the carry-in are inverted here.
   assign beff        = b ^ {WIDTH{sub}};
   assign pay_d.g     = a & beff;
   assign pay_d.p     = a ^ beff;
   assign pay_d.c0    = cin ^ sub;
   assign pay_d.sub   = sub;
   assign pay_d.a_msb = a[WIDTH-1];

   // ---- stage 1 boundary ----
   // Capture generate/propagate for an accepted beat and track occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else if (ld_p1) begin
         vld_p1 <= in_valid;
         if (in_valid)
            pay_p1 <= pay_d;
      end
   end

   prefix_carry_8 u_carry (
      .g  (pay_p1.g),
      .p  (pay_p1.p),
      .c0 (pay_p1.c0),
      .c  (c_w)
   );

   assign sum_raw = pay_p1.p ^ c_w[WIDTH-1:0];
   assign ovf_w   = c_w[WIDTH] ^ c_w[WIDTH-1];
   assign cout_w  = c_w[WIDTH] ^ pay_p1.sub;
   assign sum_fin = saturate(sum_raw, ovf_w, pay_p1.a_msb);

   // ---- stage 2 boundary ----
   // Register the final result; it holds while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         sum_p2  <= '0;
         cout_p2 <= 1'b0;
         ovf_p2  <= 1'b0;
         zero_p2 <= 1'b0;
      end else if (ld_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            sum_p2  <= sum_fin;
            cout_p2 <= cout_w;
            ovf_p2  <= ovf_w;
            zero_p2 <= (sum_fin == '0);
         end
      end
   end

   assign out_valid = vld_p2;
   assign sum       = sum_p2;
   assign cout      = cout_p2;
   assign ovf       = ovf_p2;
   assign zero      = zero_p2;

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Bench for prefix_addsub_pipe: wrap and saturating instances share stimulus
// and are compared against an arithmetic reference model.
module tb_prefix_addsub_pipe;

   typedef struct packed {
      logic [7:0] s;
      logic       co;
      logic       ov;
      logic       z;
   } res_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic       cin;
   } beat_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic       sub;
   logic       cin;
   logic       out_ready;
   logic       in_ready0, in_ready1;
   logic       out_valid0, out_valid1;
   logic [7:0] sum0, sum1;
   logic       cout0, cout1, ovf0, ovf1, zero0, zero1;

   int checks = 0;
   int failures = 0;
   beat_t q[$];

   prefix_addsub_pipe #(.SAT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .a(a), .b(b), .sub(sub), .cin(cin),
      .out_valid(out_valid0), .out_ready(out_ready),
      .sum(sum0), .cout(cout0), .ovf(ovf0), .zero(zero0));

   prefix_addsub_pipe #(.SAT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .a(a), .b(b), .sub(sub), .cin(cin),
      .out_valid(out_valid1), .out_ready(out_ready),
      .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Plain-integer reference: a+b+cin or a-b-cin, signed range test, clamp.
   function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb,
                                  input logic msub, input logic mcin, input bit sat);
      int ua, ub, sa, sb, ci, ur, sr;
      res_t r;
      ua = ma;  ub = mb;  ci = mcin;
      sa = $signed(ma);  sb = $signed(mb);
      if (!msub) begin
         ur = ua + ub + ci;  sr = sa + sb + ci;  r.co = (ur > 255);
      end else begin
         ur = ua - ub - ci;  sr = sa - sb - ci;  r.co = (ur < 0);
      end
      r.s  = ur[7:0];
      r.ov = (sr > 127) || (sr < -128);
      if (sat && r.ov) r.s = (sr < 0) ? 8'h80 : 8'h7F;
      r.z  = (r.s == 8'h00);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle: check the head result (also while stalled), then log acceptance.
   always @(negedge clk) begin
      res_t e0, e1;
      if (!rst) begin
         chk("out_valid_pair", {31'd0, out_valid1}, {31'd0, out_valid0});
         if (out_valid0) begin
            if (q.size() == 0) begin
               chk("stale_result", 32'd1, 32'd0);
            end else begin
               e0 = model(q[0].a, q[0].b, q[0].sub, q[0].cin, 1'b0);
               e1 = model(q[0].a, q[0].b, q[0].sub, q[0].cin, 1'b1);
               chk("wrap_result", {20'd0, sum0, cout0, ovf0, zero0}, {20'd0, e0});
               chk("sat_result",  {20'd0, sum1, cout1, ovf1, zero1}, {20'd0, e1});
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready0) q.push_back('{a: a, b: b, sub: sub, cin: cin});
      end else begin
         q.delete();
      end
   end

   task automatic directed(input string name, input logic [7:0] va, input logic [7:0] vb,
                           input logic vsub, input logic vcin,
                           input logic [7:0] s0, input logic co, input logic ov,
                           input logic z, input logic [7:0] s1);
      @(posedge clk); #1;
      a = va; b = vb; sub = vsub; cin = vcin; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk({name, "_in_ready"}, {31'd0, in_ready0}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({name, "_early_valid"}, {31'd0, out_valid0}, 32'd0);
      @(negedge clk);
      chk({name, "_valid"}, {31'd0, out_valid0}, 32'd1);
      chk({name, "_wrap"}, {20'd0, sum0, cout0, ovf0, zero0}, {20'd0, s0, co, ov, z});
      chk({name, "_sat_sum"}, {24'd0, sum1}, {24'd0, s1});
   endtask

   initial begin
      res_t r;
      int idx, cyc, nvalid;
      beat_t bp[3];

      rst = 1'b1; in_valid = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0;
      out_ready = 1'b1;

      // Model pinned by hand-computed values.
      r = model(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0); chk("model_7f_wrap", {20'd0, r}, {20'd0, 8'h80, 1'b0, 1'b1, 1'b0});
      r = model(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1); chk("model_7f_sat",  {20'd0, r}, {20'd0, 8'h7F, 1'b0, 1'b1, 1'b0});
      r = model(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0); chk("model_ff",      {20'd0, r}, {20'd0, 8'h00, 1'b1, 1'b0, 1'b1});
      r = model(8'h00, 8'h01, 1'b1, 1'b0, 1'b0); chk("model_borrow",  {20'd0, r}, {20'd0, 8'hFF, 1'b1, 1'b0, 1'b0});
      r = model(8'h80, 8'h01, 1'b1, 1'b0, 1'b1); chk("model_80_sat",  {20'd0, r}, {20'd0, 8'h80, 1'b0, 1'b1, 1'b0});
      r = model(8'h10, 8'h05, 1'b1, 1'b1, 1'b0); chk("model_bin",     {20'd0, r}, {20'd0, 8'h0A, 1'b0, 1'b0, 1'b0});

      // Reset, with a beat offered throughout that must not be taken.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready0}, 32'd1);
      chk("rst_outputs",   {20'd0, sum0, cout0, ovf0, zero0}, 32'd0);
      chk("rst_outputs_sat", {20'd0, sum1, cout1, ovf1, zero1}, 32'd0);
      repeat (2) @(negedge clk);
      chk("rst_no_ghost", {31'd0, out_valid0}, 32'd0);

      directed("ovf_add",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 8'h7F);
      directed("carry_ff", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00);
      directed("borrow",   8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF);
      directed("ovf_sub",  8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 8'h80);
      directed("cin_sub",  8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 8'h0A);

      // Backpressure: three beats against a stalled consumer.
      bp[0] = '{a: 8'h01, b: 8'h01, sub: 1'b0, cin: 1'b0};
      bp[1] = '{a: 8'h02, b: 8'h02, sub: 1'b0, cin: 1'b0};
      bp[2] = '{a: 8'h03, b: 8'h03, sub: 1'b0, cin: 1'b0};
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b0;
         in_valid = (idx < 3);
         if (idx < 3) begin a = bp[idx].a; b = bp[idx].b; sub = bp[idx].sub; cin = bp[idx].cin; end
         @(negedge clk);
         if (in_valid && in_ready0) idx++;
      end
      chk("bp_accepted", idx, 2);
      chk("bp_in_ready", {31'd0, in_ready0}, 32'd0);
      chk("bp_hold_sum", {24'd0, sum0}, 32'h02);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         in_valid = (idx < 3);
         if (idx < 3) begin a = bp[idx].a; b = bp[idx].b; sub = bp[idx].sub; cin = bp[idx].cin; end
         @(negedge clk);
         chk("bp_drain_valid", {31'd0, out_valid0}, 32'd1);
         chk("bp_drain_sum", {24'd0, sum0}, 32'(2 * (c + 1)));
         if (in_valid && in_ready0) idx++;
      end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp_empty", {31'd0, out_valid0}, 32'd0);

      // Full throughput: eight back-to-back beats, eight consecutive results.
      nvalid = 0; idx = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b1;
         in_valid = (c < 8);
         a = 8'(c * 17); b = 8'(c * 29 + 3); sub = c[0]; cin = c[1];
         @(negedge clk);
         if (in_valid && in_ready0) idx++;
         if (out_valid0) nvalid++;
      end
      chk("tput_accepted", idx, 8);
      chk("tput_results", nvalid, 8);

      // Random operands with random stalls on both sides.
      idx = 0; cyc = 0;
      while (idx < 10000 && cyc < 60000) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
         @(negedge clk);
         if (in_valid && in_ready0) idx++;
         cyc++;
      end
      chk("rand_accepted", idx, 10000);
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      cyc = 0;
      while (q.size() != 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("rand_drained", q.size(), 0);

      // Reset with both stages full and a beat offered during reset.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         out_ready = 1'b0; in_valid = 1'b1;
         a = 8'h11 + 8'(c); b = 8'h22; sub = 1'b0; cin = 1'b0;
      end
      @(negedge clk);
      chk("mid_full", {30'd0, out_valid0, in_ready0}, 32'b10);
      @(posedge clk); #1;
      rst = 1'b1; a = 8'h55; b = 8'h01;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", {31'd0, out_valid0}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready0}, 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("mid_rst_no_stale", {31'd0, out_valid0}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
